cgra_clock_gate_ctrl: RTL and testbench



---
 rtl/cgra_clock_gate_ctrl.sv | 126 ++++++++++++
 tb/tb_cgra_clock_gate_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cgra_clock_gate_ctrl.sv
// Enable controller for the CGRA clock-gate cell: request/ack wake sequence plus idle hold-off.
// Optional gated-cycle statistics counter is built only when CGRA_CLKGATE_STATS_EN is defined.
module cgra_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             busy_i,
    input  logic             force_i,
    output logic             en_o,
    output logic             ack_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] gated_cnt_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
    localparam logic [7:0] IDLE_LOAD = 8'(IDLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic       r_en;
    logic       r_ack;
    logic       w_en_nxt;
    logic       w_ack_nxt;
    logic       w_act;

    assign w_act = req_i | busy_i | force_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_OFF;
            r_cnt   <= 8'd0;
            r_en    <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // The counter is shared: it times the wake settle in WAKE and the idle window in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_OFF: begin
                if (req_i || force_i) begin
                    if (WAKE_CYCLES == 0) begin
                        w_state_nxt = ST_ON;
                    end else begin
                        w_state_nxt = ST_WAKE;
                        w_cnt_nxt   = WAKE_LOAD;
                    end
                end
            end
            ST_WAKE: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_ON: begin
                if (!w_act) begin
                    if (IDLE_CYCLES == 0) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = IDLE_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                // Activity wins over an expiring idle window; the clock never stopped.
                if (w_act) begin
                    w_state_nxt = ST_ON;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    assign w_en_nxt  = (w_state_nxt != ST_OFF);
    assign w_ack_nxt = (w_state_nxt == ST_ON);

    assign en_o    = r_en;
    assign ack_o   = r_ack;
    assign state_o = r_state;

`ifdef CGRA_CLKGATE_STATS_EN
    logic [CNT_W-1:0] r_gated_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gated_cnt <= '0;
        end else if (!r_en && (r_gated_cnt != {CNT_W{1'b1}})) begin
            r_gated_cnt <= r_gated_cnt + CNT_W'(1);
        end
    end

    assign gated_cnt_o = r_gated_cnt;
`else
    assign gated_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
// Directed self-checking bench for cgra_clock_gate_ctrl: default parameters and the
// zero-wake/zero-idle boundary build, both with a 4-bit gated-cycle counter.
module tb_cgra_clock_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       req_a, busy_a, force_a;
    logic       en_a, ack_a;
    logic [1:0] state_a;
    logic [3:0] gcnt_a;
    logic       req_b, busy_b, force_b;
    logic       en_b, ack_b;
    logic [1:0] state_b;
    logic [3:0] gcnt_b;

    int err_cnt = 0;
    int chk_cnt = 0;
    bit left_on;

    cgra_clock_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .busy_i(busy_a), .force_i(force_a),
        .en_o(en_a), .ack_o(ack_a), .state_o(state_a), .gated_cnt_o(gcnt_a)
    );

    cgra_clock_gate_ctrl #(.IDLE_CYCLES(0), .WAKE_CYCLES(0), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .busy_i(busy_b), .force_i(force_b),
        .en_o(en_b), .ack_o(ack_b), .state_o(state_b), .gated_cnt_o(gcnt_b)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance one edge; outputs sampled and inputs driven 1ns after it
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] stat_exp(input int v);
`ifdef CGRA_CLKGATE_STATS_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    task automatic chk_a(input string tag, input logic e, input logic a, input logic [1:0] s);
        check({tag, ".en"}, 32'(en_a), 32'(e));
        check({tag, ".ack"}, 32'(ack_a), 32'(a));
        check({tag, ".state"}, 32'(state_a), 32'(s));
    endtask

    initial begin
        req_a = 0; busy_a = 0; force_a = 0;
        req_b = 0; busy_b = 0; force_b = 0;
        rst = 1'b1;
        #1;
        chk_a("async_reset_init", 1'b0, 1'b0, 2'd0);
        check("reset_gcnt", 32'(gcnt_a), 32'd0);
        tick(2);
        rst = 1'b0;

        // statistics: 3 cycles then saturation after 20 in OFF
        tick(3);
        check("gcnt_3", 32'(gcnt_a), stat_exp(3));
        tick(17);
        check("gcnt_sat", 32'(gcnt_a), stat_exp(15));
        chk_a("off_idle", 1'b0, 1'b0, 2'd0);

        // wake sequence with default parameters
        do_reset();
        req_a = 1;
        tick();
        chk_a("wake_e0", 1'b1, 1'b0, 2'd1);
        tick();
        chk_a("wake_e1", 1'b1, 1'b0, 2'd1);
        tick();
        chk_a("wake_e2", 1'b1, 1'b1, 2'd2);
        tick(7);
        req_a = 0;
        tick();
        chk_a("release_e10", 1'b1, 1'b0, 2'd3);
        tick(15);
        chk_a("release_e25", 1'b1, 1'b0, 2'd3);
        tick();
        chk_a("release_e26", 1'b0, 1'b0, 2'd0);

        // HOLD re-entry via busy at counter=5, then via req
        req_a = 1;
        tick(3);
        chk_a("rewake_on", 1'b1, 1'b1, 2'd2);
        req_a = 0;
        tick();
        tick(10);
        chk_a("hold_cnt5", 1'b1, 1'b0, 2'd3);
        busy_a = 1;
        tick();
        chk_a("hold_busy_on", 1'b1, 1'b1, 2'd2);
        busy_a = 0;
        tick();
        chk_a("hold_again", 1'b1, 1'b0, 2'd3);
        req_a = 1;
        tick();
        chk_a("hold_req_on", 1'b1, 1'b1, 2'd2);

        // dropping req mid-wake does not abort it
        req_a = 0;
        tick(17);
        chk_a("back_off", 1'b0, 1'b0, 2'd0);
        req_a = 1;
        tick();
        req_a = 0;
        tick(2);
        chk_a("wake_no_abort", 1'b1, 1'b1, 2'd2);
        tick(17);
        chk_a("no_abort_off", 1'b0, 1'b0, 2'd0);

        // busy alone does not wake
        busy_a = 1;
        tick(5);
        chk_a("busy_only", 1'b0, 1'b0, 2'd0);
        busy_a = 0;

        // force holds the clock on indefinitely
        force_a = 1;
        left_on = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (state_a == 2'd0) left_on = 1'b0;
            tick();
        end
        check("force_never_off", 32'(left_on), 32'd1);
        chk_a("force_on", 1'b1, 1'b1, 2'd2);
        force_a = 0;
        tick(17);
        chk_a("force_release", 1'b0, 1'b0, 2'd0);

        // activity on the edge the HOLD counter expires
        req_a = 1;
        tick(3);
        req_a = 0;
        tick(16);
        chk_a("hold_expiring", 1'b1, 1'b0, 2'd3);
        busy_a = 1;
        tick();
        chk_a("expire_act_wins", 1'b1, 1'b1, 2'd2);
        busy_a = 0;

        // async reset mid-HOLD
        tick(4);
        chk_a("pre_rst_hold", 1'b1, 1'b0, 2'd3);
        #2 rst = 1'b1;
        #1;
        chk_a("rst_mid_hold", 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        tick();

        // async reset mid-WAKE
        req_a = 1;
        tick();
        chk_a("pre_rst_wake", 1'b1, 1'b0, 2'd1);
        #2 rst = 1'b1;
        #1;
        chk_a("rst_mid_wake", 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        req_a = 0;
        tick();

        // boundary build: zero wake and zero idle
        do_reset();
        req_b = 1;
        tick();
        check("b_en_same_edge", 32'(en_b), 32'd1);
        check("b_ack_same_edge", 32'(ack_b), 32'd1);
        check("b_state_on", 32'(state_b), 32'd2);
        req_b = 0;
        tick();
        check("b_en_off", 32'(en_b), 32'd0);
        check("b_ack_off", 32'(ack_b), 32'd0);
        check("b_state_off", 32'(state_b), 32'd0);
        tick(3);
        check("b_gcnt", 32'(gcnt_b), stat_exp(4));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
